phy_reset_gen: RTL and testbench

- Generates the timed active-low hardware reset driven out to the external Ethernet PHY pin.
- Signals fabric logic when the PHY is out of reset and past its settle time.
- Accepts a single-cycle request to re-run the PHY reset sequence (link recovery).
- Sits at the board edge, fed by the design's already-conditioned active-low reset.

---
 rtl/phy_reset_gen.sv | 136 +++++++++++++
 tb/tb_phy_reset_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/phy_reset_gen.sv
// phy_reset_gen: timed active-low reset for an external Ethernet PHY.
// Holds the PHY in reset for ASSERT_CYCLES, waits RELEASE_CYCLES for it to
// settle, then reports ready. A one-cycle req re-runs the sequence.
// Optional feature macro: PHY_RESET_PLL_LOCK_EN adds a pll_locked input that
// gates the assert count and forces a restart when lock is lost.
module phy_reset_gen #(
    parameter int ASSERT_CYCLES  = 250000,
    parameter int RELEASE_CYCLES = 125000,
    parameter int CNT_W          = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
`ifdef PHY_RESET_PLL_LOCK_EN
    input  logic pll_locked,
`endif
    output logic phy_rst_n,
    output logic ready,
    output logic busy,
    output logic done
);

    // Both cycle counts must be non-zero and representable in the counter.
    if ((ASSERT_CYCLES < 1) || (longint'(ASSERT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_assert
        $error("phy_reset_gen: ASSERT_CYCLES must be >=1 and fit in CNT_W bits");
    end
    if ((RELEASE_CYCLES < 1) || (longint'(RELEASE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_release
        $error("phy_reset_gen: RELEASE_CYCLES must be >=1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phy_rst_n;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_lock;
    logic             w_restart;

`ifdef PHY_RESET_PLL_LOCK_EN
    logic r_lock_meta;
    logic r_lock_sync;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end
    assign w_lock = r_lock_sync;
`else
    assign w_lock = 1'b1;
`endif

    // Losing lock outside ASSERT has the same effect as a restart request.
    assign w_restart = req | ~w_lock;

    // Sequencer: state, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_phy_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_ASSERT: begin
                    // req is ignored here; count only advances while locked.
                    if (w_lock) begin
                        if (r_cnt == A_LAST) begin
                            r_cnt       <= '0;
                            r_state     <= ST_RELEASE;
                            r_phy_rst_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    // A restart beats the READY transition on the same edge.
                    if (w_restart) begin
                        r_cnt       <= '0;
                        r_state     <= ST_ASSERT;
                        r_phy_rst_n <= 1'b0;
                    end else if (r_cnt == R_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    r_cnt <= '0;
                    if (w_restart) begin
                        r_state     <= ST_ASSERT;
                        r_phy_rst_n <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ASSERT;
                    r_cnt       <= '0;
                    r_phy_rst_n <= 1'b0;
                    r_ready     <= 1'b0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    assign phy_rst_n = r_phy_rst_n;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_phy_reset_gen.sv
// Directed bench for phy_reset_gen with ASSERT_CYCLES=8, RELEASE_CYCLES=4.
// Edge numbers in the tables count rising edges from the edge that samples
// the triggering event (rst_n release or req).
module tb_phy_reset_gen;

    localparam int AC = 8;
    localparam int RC = 4;
`ifdef PHY_RESET_PLL_LOCK_EN
    localparam int PL = 2;   // synchronizer delay before counting starts after reset
`else
    localparam int PL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic phy_rst_n, ready, busy, done;
`ifdef PHY_RESET_PLL_LOCK_EN
    logic pll_locked = 1'b1;
`endif

    int errors = 0;
    int checks = 0;

    phy_reset_gen #(.ASSERT_CYCLES(AC), .RELEASE_CYCLES(RC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef PHY_RESET_PLL_LOCK_EN
        .pll_locked(pll_locked),
`endif
        .phy_rst_n (phy_rst_n),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) tick();
        checks++; if ({phy_rst_n, ready, busy, done} !== 4'b0010) begin
            errors++; $display("FAIL reset_vals got=%b exp=0010", {phy_rst_n, ready, busy, done});
        end
    endtask

    // Releases rst_n and follows the full power-on sequence.
    task automatic test_power_on();
        rst_n = 1'b1;
        for (int k = 1; k <= AC + RC + PL + 2; k++) begin
            tick();
            checks++; if ({phy_rst_n, ready, busy, done} !==
                          {1'(k >= AC + PL), 1'(k >= AC + RC + PL), 1'(k < AC + RC + PL), 1'(k == AC + RC + PL)}) begin
                errors++; $display("FAIL power_on k=%0d got=%b exp=%b", k, {phy_rst_n, ready, busy, done},
                    {1'(k >= AC + PL), 1'(k >= AC + RC + PL), 1'(k < AC + RC + PL), 1'(k == AC + RC + PL)});
            end
        end
    endtask

    task automatic test_rereset();
        for (int k = 1; k <= 14; k++) begin
            req = (k == 1);
            tick();
            req = 1'b0;
            checks++; if ({phy_rst_n, ready, busy, done} !== {1'(k >= 9), 1'(k >= 13), 1'(k < 13), 1'(k == 13)}) begin
                errors++; $display("FAIL rereset k=%0d got=%b exp=%b", k, {phy_rst_n, ready, busy, done},
                    {1'(k >= 9), 1'(k >= 13), 1'(k < 13), 1'(k == 13)});
            end
        end
    endtask

    task automatic test_req_assert();
        for (int k = 1; k <= 14; k++) begin
            req = (k == 1) || (k == 4);
            tick();
            req = 1'b0;
            checks++; if ({phy_rst_n, ready, done} !== {1'(k >= 9), 1'(k >= 13), 1'(k == 13)}) begin
                errors++; $display("FAIL req_assert k=%0d got=%b exp=%b", k, {phy_rst_n, ready, done},
                    {1'(k >= 9), 1'(k >= 13), 1'(k == 13)});
            end
        end
    endtask

    task automatic test_req_release();
        for (int k = 1; k <= 24; k++) begin
            req = (k == 1) || (k == 11);
            tick();
            req = 1'b0;
            checks++; if ({phy_rst_n, ready, done} !== {1'((k >= 9 && k < 11) || k >= 19), 1'(k >= 23), 1'(k == 23)}) begin
                errors++; $display("FAIL req_release k=%0d got=%b exp=%b", k, {phy_rst_n, ready, done},
                    {1'((k >= 9 && k < 11) || k >= 19), 1'(k >= 23), 1'(k == 23)});
            end
        end
    endtask

    task automatic test_req_on_ready_entry();
        for (int k = 1; k <= 26; k++) begin
            req = (k == 1) || (k == 13);
            tick();
            req = 1'b0;
            checks++; if ({phy_rst_n, ready, busy, done} !==
                          {1'((k >= 9 && k < 13) || k >= 21), 1'(k >= 25), 1'(k < 25), 1'(k == 25)}) begin
                errors++; $display("FAIL req_ready_entry k=%0d got=%b exp=%b", k, {phy_rst_n, ready, busy, done},
                    {1'((k >= 9 && k < 13) || k >= 21), 1'(k >= 25), 1'(k < 25), 1'(k == 25)});
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 1; k <= 10; k++) begin
            req = (k == 1);
            tick();
            req = 1'b0;
        end
        checks++; if (phy_rst_n !== 1'b1) begin
            errors++; $display("FAIL mid_pre_phy got=%b exp=1", phy_rst_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({phy_rst_n, ready, busy, done} !== 4'b0010) begin
            errors++; $display("FAIL mid_async got=%b exp=0010", {phy_rst_n, ready, busy, done});
        end
        repeat (2) tick();
        test_power_on();
    endtask

`ifdef PHY_RESET_PLL_LOCK_EN
    task automatic test_pll_lock();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if ({phy_rst_n, busy} !== 2'b01) begin
                errors++; $display("FAIL pll_wait k=%0d got=%b exp=01", k, {phy_rst_n, busy});
            end
        end
        pll_locked = 1'b1;
        for (int k = 21; k <= 37; k++) begin
            if (k == 35) pll_locked = 1'b0;
            tick();
            checks++; if ({phy_rst_n, ready, done} !== {1'(k >= 30 && k < 37), 1'(k >= 34 && k < 37), 1'(k == 34)}) begin
                errors++; $display("FAIL pll_lock k=%0d got=%b exp=%b", k, {phy_rst_n, ready, done},
                    {1'(k >= 30 && k < 37), 1'(k >= 34 && k < 37), 1'(k == 34)});
            end
        end
        pll_locked = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_power_on();
        test_rereset();
        test_req_assert();
        test_req_release();
        test_req_on_ready_entry();
        test_mid_reset();
`ifdef PHY_RESET_PLL_LOCK_EN
        test_pll_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
